// File: rtl/bank_arb_pkg.sv
// Shared types and helpers for the per-bank round-robin arbiter.
// FSM state encoding, default geometry constants and a width helper.
package bank_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam int DEF_N_CORES     = 16;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_OFFS_W      = 8;
    localparam int DEF_BANK_W      = 4;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Minimum 1 so that single-value ranges still get a legal vector width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

    function automatic int core_addr_w(input int bank_w, input int offs_w);
        return bank_w + offs_w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of eligible at or
// after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int pos;

    // Scan from the farthest offset back to ptr so the closest hit wins.
    always_comb begin
        any = |eligible;
        idx = '0;
        pos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N;
            if (eligible[pos]) begin
                idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bank_arbiter_rr.sv
// Per-bank round-robin arbiter: one core access at a time onto a
// variable-latency bank handshake. Optional abort timer: BANK_ARB_TIMEOUT_EN.
module bank_arbiter_rr
    import bank_arb_pkg::*;
#(
    parameter int N_CORES     = DEF_N_CORES,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int OFFS_W      = DEF_OFFS_W,
    parameter int BANK_W      = DEF_BANK_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [BANK_W-1:0]                        bank_n,
    input  logic [N_CORES-1:0]                       req_valid,
    input  logic [N_CORES-1:0]                       req_write,
    input  logic [N_CORES*(BANK_W+OFFS_W)-1:0]       req_addr,
    input  logic [N_CORES*DATA_W-1:0]                req_wdata,
    output logic [N_CORES*DATA_W-1:0]                core_rdata,
    output logic [N_CORES-1:0]                       core_done,
    output logic [N_CORES-1:0]                       core_err,
    output logic                                     bank_req,
    output logic                                     bank_we,
    output logic [OFFS_W-1:0]                        bank_addr,
    output logic [DATA_W-1:0]                        bank_wdata,
    input  logic [DATA_W-1:0]                        bank_rdata,
    input  logic                                     bank_ack
);

    localparam int AW    = core_addr_w(BANK_W, OFFS_W);
    localparam int IDX_W = clog2(N_CORES);

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         gnt_q, gnt_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                     we_q, we_d;
    logic [OFFS_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [N_CORES*DATA_W-1:0] rdata_q, rdata_d;
    logic [N_CORES-1:0]       done_q, done_d;

    logic [N_CORES-1:0]       eligible;
    logic                     pick_any;
    logic [IDX_W-1:0]         pick_idx;

`ifdef BANK_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N_CORES-1:0]       err_q, err_d;
`endif

    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            eligible[i] = req_valid[i] && (req_addr[i*AW+OFFS_W +: BANK_W] == bank_n);
        end
    end

    rr_pick #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = '0;
`ifdef BANK_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_idx;
                    we_d     = req_write[pick_idx];
                    addr_d   = req_addr[int'(pick_idx)*AW +: OFFS_W];
                    wdata_d  = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    rr_ptr_d = (int'(pick_idx) == N_CORES - 1) ? '0 : pick_idx + 1'b1;
`ifdef BANK_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (bank_ack) begin
                    if (!we_q) begin
                        rdata_d[int'(gnt_q)*DATA_W +: DATA_W] = bank_rdata;
                    end
                    done_d[gnt_q] = 1'b1;
                    state_d       = ST_RESP;
                end
`ifdef BANK_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= '0;
`ifdef BANK_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
`ifdef BANK_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Strobe decoded from state so an async reset drops it immediately.
    assign bank_req   = (state_q == ST_ISSUE);
    assign bank_we    = we_q;
    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;
    assign core_rdata = rdata_q;
    assign core_done  = done_q;
`ifdef BANK_ARB_TIMEOUT_EN
    assign core_err   = err_q;
`else
    assign core_err   = '0;
`endif

endmodule

// File: tb/tb_bank_arbiter_rr.sv
// Directed bench for bank_arbiter_rr (16 cores, 8-bit data, 4-bit bank field).
// The timeout scenarios are compiled in with BANK_ARB_TIMEOUT_EN.
module tb_bank_arbiter_rr;

    localparam int N   = 16;
    localparam int DW  = 8;
    localparam int OW  = 8;
    localparam int BW  = 4;
    localparam int AW  = BW + OW;
    localparam int TO  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [BW-1:0]     bank_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*DW-1:0]   core_rdata;
    logic [N-1:0]      core_done;
    logic [N-1:0]      core_err;
    logic              bank_req;
    logic              bank_we;
    logic [OW-1:0]     bank_addr;
    logic [DW-1:0]     bank_wdata;
    logic [DW-1:0]     bank_rdata;
    logic              bank_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    bank_arbiter_rr #(
        .N_CORES     (N),
        .DATA_W      (DW),
        .OFFS_W      (OW),
        .BANK_W      (BW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bank_n     (bank_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .core_rdata (core_rdata),
        .core_done  (core_done),
        .core_err   (core_err),
        .bank_req   (bank_req),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .bank_ack   (bank_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[c]          = 1'b1;
        req_write[c]          = w;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rd_slice(input int c);
        return core_rdata[c*DW +: DW];
    endfunction

    // Bounded wait for the next done pulse; always advances at least one cycle.
    task automatic wait_done(input string tag, input logic [N-1:0] exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (core_done == '0 && n < 12);
        check(tag, core_done, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order [6];
        int cnt;
        int bad;
        order = '{0, 7, 15, 0, 7, 15};

        reset      = 1'b1;
        bank_n     = 4'd3;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        bank_rdata = '0;
        bank_ack   = 1'b0;
        tick(); tick(); tick();
        check("rst_bank_req", bank_req, 1'b0);
        check("rst_done", core_done, '0);
        check("rst_rdata_zero", 64'(core_rdata == '0), 64'd1);
        reset = 1'b0;
        tick();

        // Single read, ack in first ISSUE cycle: done two cycles after valid.
        set_req(5, 1'b0, 12'h32A, 8'h00);
        tick();
        check("rd_issue_req", bank_req, 1'b1);
        check("rd_issue_addr", bank_addr, 8'h2A);
        check("rd_issue_we", bank_we, 1'b0);
        check("rd_issue_nodone", core_done, '0);
        bank_ack   = 1'b1;
        bank_rdata = 8'h5C;
        tick();
        check("rd_done", core_done, 16'h0020);
        check("rd_data5", rd_slice(5), 8'h5C);
        check("rd_req_dropped", bank_req, 1'b0);
        check("rd_err", core_err, '0);
        req_valid[5] = 1'b0;
        bank_ack     = 1'b0;
        tick();
        check("rd_done_one_cycle", core_done, '0);

        // Reset while an access is pending with ack held low.
        set_req(1, 1'b1, 12'h301, 8'h3C);
        tick(); tick(); tick();
        check("pre_rst_req", bank_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst_bank_req", bank_req, 1'b0);
        check("midrst_we", bank_we, 1'b0);
        check("midrst_addr", bank_addr, 8'h00);
        check("midrst_wdata", bank_wdata, 8'h00);
        check("midrst_rdata_zero", 64'(core_rdata == '0), 64'd1);
        check("midrst_done", core_done, '0);
        req_valid = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", bank_req, 1'b0);

        // Three cores contend, each re-requests right away.
        bank_ack   = 1'b1;
        bank_rdata = 8'h4B;
        set_req(0,  1'b0, 12'h300, 8'h00);
        set_req(7,  1'b0, 12'h307, 8'h00);
        set_req(15, 1'b0, 12'h30F, 8'h00);
        for (int g = 0; g < 6; g++) begin
            wait_done($sformatf("rr_order_%0d", g), N'(1) << order[g]);
        end
        req_valid = '0;
        bank_ack  = 1'b0;
        check("rr_data7", rd_slice(7), 8'h4B);
        check("rr_data15", rd_slice(15), 8'h4B);
        tick(); tick();

        // Request for another bank stays invisible; left asserted from here on.
        set_req(2, 1'b0, 12'h455, 8'h00);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bank_req || core_done != '0) cnt++;
        end
        check("foreign_bank_ignored", cnt, 0);

        // Write with six-cycle bank latency: operands must hold throughout.
        bank_rdata = 8'hEE;
        set_req(9, 1'b1, 12'h310, 8'hA1);
        tick();
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (!(bank_req && bank_we && bank_addr == 8'h10 && bank_wdata == 8'hA1 && core_done == '0)) bad++;
            if (c == 5) bank_ack = 1'b1;
            else tick();
        end
        check("wr_stable_6cyc", bad, 0);
        tick();
        check("wr_done", core_done, 16'h0200);
        check("wr_req_dropped", bank_req, 1'b0);
        check("wr_rdata_untouched", rd_slice(9), 8'h00);
        check("wr_err", core_err, '0);
        req_valid[9] = 1'b0;
        bank_ack     = 1'b0;
        tick(); tick();

`ifdef BANK_ARB_TIMEOUT_EN
        // No ack: abort after TO cycles in ISSUE.
        set_req(4, 1'b0, 12'h3C4, 8'h00);
        tick();
        for (int c = 0; c < TO - 1; c++) begin
            tick();
            check($sformatf("to_wait_req_%0d", c), bank_req, 1'b1);
            check($sformatf("to_wait_done_%0d", c), core_done, '0);
        end
        tick();
        check("to_done", core_done, 16'h0010);
        check("to_err", core_err, 16'h0010);
        check("to_req_dropped", bank_req, 1'b0);
        check("to_rdata_unchanged", rd_slice(4), 8'h00);
        req_valid[4] = 1'b0;
        tick(); tick();

        // Ack on the timeout cycle completes normally.
        set_req(4, 1'b0, 12'h3C4, 8'h00);
        tick();
        for (int c = 0; c < TO - 1; c++) tick();
        bank_ack   = 1'b1;
        bank_rdata = 8'h99;
        tick();
        check("to_ack_done", core_done, 16'h0010);
        check("to_ack_err", core_err, '0);
        check("to_ack_rdata", rd_slice(4), 8'h99);
        req_valid[4] = 1'b0;
        bank_ack     = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
